// File: rtl/mips_step_sequencer.sv
// ============================================================================
// mips_step_sequencer : one-hot phase generator with free-run / debounced
//                       single-step modes and a retired-instruction counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module mips_step_sequencer #(
  parameter int PHASES     = 4,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_ok_i,
  input  logic              run_mode_i,
  input  logic              halt_i,
  output logic [PHASES-1:0] timer_o,
  output logic              instr_done_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  retired_cnt_o
);

  localparam int             DCW     = $clog2(DEB_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_MAX = DCW'(DEB_CYCLES);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_t;

  logic [1:0]        sync_q;
  logic              deb_q, deb_d;
  logic              deb_prev_q;
  logic [DCW-1:0]    dcnt_q, dcnt_d;
  logic              step_req;

  state_t            state_q;
  logic [PHASES-1:0] timer_q;
  logic [CNT_W-1:0]  retired_q;

  // The level only flips after the synced input has disagreed with it for
  // DEB_CYCLES+1 consecutive samples; any agreement restarts the count.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (dcnt_q == DEB_MAX) begin
        deb_d  = sync_q[1];
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + DCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b00;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      dcnt_q     <= '0;
    end else begin
      sync_q     <= {sync_q[0], key_ok_i};
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      dcnt_q     <= dcnt_d;
    end
  end

  assign step_req = deb_q & ~deb_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!halt_i && (run_mode_i || step_req)) begin
            state_q <= ST_EXEC;
            timer_q <= PHASES'(1);
          end
        end
        ST_EXEC: begin
          if (timer_q[PHASES-1]) begin
            retired_q <= retired_q + CNT_W'(1);
            if (!halt_i && run_mode_i) begin
              timer_q <= PHASES'(1);
            end else begin
              state_q <= ST_IDLE;
              timer_q <= '0;
            end
          end else begin
            timer_q <= {timer_q[PHASES-2:0], 1'b0};
          end
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign timer_o       = timer_q;
  assign instr_done_o  = timer_q[PHASES-1];
  assign busy_o        = |timer_q;
  assign retired_cnt_o = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_step_sequencer.sv
// ============================================================================
// tb_mips_step_sequencer : scoreboard bench for two configurations of the
//                          step sequencer against an instruction-level model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mips_step_sequencer;

  logic clk = 1'b0;
  logic rst, key_ok, run_mode, halt;

  logic [3:0] timer_a;
  logic       done_a, busy_a;
  logic [15:0] cnt_a;
  logic [5:0] timer_b;
  logic       done_b, busy_b;
  logic [2:0] cnt_b;

  always #5 clk = ~clk;

  mips_step_sequencer #(.PHASES(4), .DEB_CYCLES(16), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .key_ok_i(key_ok), .run_mode_i(run_mode), .halt_i(halt),
    .timer_o(timer_a), .instr_done_o(done_a), .busy_o(busy_a), .retired_cnt_o(cnt_a)
  );

  mips_step_sequencer #(.PHASES(6), .DEB_CYCLES(4), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .key_ok_i(key_ok), .run_mode_i(run_mode), .halt_i(halt),
    .timer_o(timer_b), .instr_done_o(done_b), .busy_o(busy_b), .retired_cnt_o(cnt_b)
  );

  typedef struct {
    int timer;
    bit done;
    bit busy;
    int cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int vectors = 0;
  int miscompares = 0;

  // Model configuration and state, one slot per DUT.
  int c_p[2]   = '{4, 6};
  int c_deb[2] = '{16, 4};
  int c_cw[2]  = '{16, 3};
  int s1[2], s2[2], deb[2], dprev[2], mism[2], ret[2];
  int phase[2] = '{-1, -1};

  task automatic model_edge(input int d, input bit r, input bit k, input bit m,
                            input bit h, output exp_t e);
    bit step;
    if (r) begin
      s1[d] = 0; s2[d] = 0; deb[d] = 0; dprev[d] = 0; mism[d] = 0;
      phase[d] = -1; ret[d] = 0;
    end else begin
      step = (deb[d] != 0) && (dprev[d] == 0);
      if (phase[d] < 0) begin
        if (!h && (m || step)) phase[d] = 0;
      end else if (phase[d] == c_p[d] - 1) begin
        ret[d]   = (ret[d] + 1) % (1 << c_cw[d]);
        phase[d] = (!h && m) ? 0 : -1;
      end else begin
        phase[d] = phase[d] + 1;
      end
      dprev[d] = deb[d];
      if (s2[d] != deb[d]) begin
        mism[d] = mism[d] + 1;
        if (mism[d] > c_deb[d]) begin
          deb[d]  = s2[d];
          mism[d] = 0;
        end
      end else begin
        mism[d] = 0;
      end
      s2[d] = s1[d];
      s1[d] = int'(k);
    end
    e.timer = (phase[d] < 0) ? 0 : (1 << phase[d]);
    e.done  = (phase[d] == c_p[d] - 1);
    e.busy  = (phase[d] >= 0);
    e.cnt   = ret[d];
  endtask

  task automatic cyc(input bit r, input bit k, input bit m, input bit h);
    exp_t ea, eb;
    rst = r; key_ok = k; run_mode = m; halt = h;
    model_edge(0, r, k, m, h, ea);
    model_edge(1, r, k, m, h, eb);
    qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clk);
    #2;
  endtask

  task automatic check(input int d, input exp_t e, input int t, input bit dn,
                       input bit bz, input int c);
    vectors++;
    if (t != e.timer || dn != e.done || bz != e.busy || c != e.cnt) begin
      miscompares++;
      $display("FAIL dut%0d t=%0t: got timer=%0h done=%0b busy=%0b cnt=%0d, required timer=%0h done=%0b busy=%0b cnt=%0d",
               d, $time, t, dn, bz, c, e.timer, e.done, e.busy, e.cnt);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check(0, e, int'(timer_a), done_a, busy_a, int'(cnt_a));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check(1, e, int'(timer_b), done_b, busy_b, int'(cnt_b));
      end
    end
  end

  initial begin : stimulus
    int len;
    bit k, m, h, r;
    rst = 1'b1; key_ok = 1'b0; run_mode = 1'b0; halt = 1'b0;
    repeat (3) cyc(1, 0, 0, 0);
    // Clean held press, then release.
    repeat (40) cyc(0, 1, 0, 0);
    repeat (30) cyc(0, 0, 0, 0);
    // Bounce: 5-cycle pulses.
    for (int i = 0; i < 10; i++) repeat (5) cyc(0, (i % 2) == 0, 0, 0);
    repeat (30) cyc(0, 0, 0, 0);
    // Free-run, then halt arriving mid-instruction with a key press held.
    repeat (40) cyc(0, 0, 1, 0);
    repeat (2) cyc(0, 0, 1, 0);
    repeat (30) cyc(0, 1, 1, 1);
    repeat (10) cyc(0, 0, 0, 0);
    // Reset in the middle of an instruction.
    repeat (7) cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    repeat (6) cyc(0, 0, 0, 0);
    // Repeated short presses: wraps the 3-bit counter of the small config.
    for (int i = 0; i < 10; i++) begin
      repeat (8) cyc(0, 1, 0, 0);
      repeat (8) cyc(0, 0, 0, 0);
    end
    // Long presses for the default config.
    for (int i = 0; i < 3; i++) begin
      repeat (22) cyc(0, 1, 0, 0);
      repeat (22) cyc(0, 0, 0, 0);
    end
    // Randomized segments.
    for (int s = 0; s < 80; s++) begin
      len = $urandom_range(1, 40);
      k   = 1'($urandom_range(0, 1));
      m   = ($urandom_range(0, 3) == 0);
      h   = ($urandom_range(0, 4) == 0);
      r   = ($urandom_range(0, 30) == 0);
      cyc(r, k, m, h);
      repeat (len) cyc(0, k, m, h);
    end
    repeat (3) @(negedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending entries, required 0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
